// File: rtl/uart_pkg.sv
// Shared constants and state encodings for the byte-wide UART bus device.
//   - frame length, default baud divider
//   - COM1 data/command base addresses used by the controller's decode
//   - TX/RX FSM state encodings
package uart_pkg;

  localparam int UART_FRAME_BITS      = 10;   // start + 8 data + stop
  localparam int UART_CLK_DIV_DEFAULT = 16;

  localparam logic [31:0] COM1_DATA_ADDR = 32'hBFD0_03F8;
  localparam logic [31:0] COM1_CMD_ADDR  = 32'hBFD0_03FC;

  // State encodings are plain vectors so older tools and probes see stable codes.
  typedef logic [1:0] tx_state_t;
  localparam tx_state_t TX_IDLE  = 2'd0;
  localparam tx_state_t TX_START = 2'd1;
  localparam tx_state_t TX_DATA  = 2'd2;
  localparam tx_state_t TX_STOP  = 2'd3;

  typedef logic [2:0] rx_state_t;
  localparam rx_state_t RX_IDLE      = 3'd0;
  localparam rx_state_t RX_START     = 3'd1;
  localparam rx_state_t RX_DATA      = 3'd2;
  localparam rx_state_t RX_STOP      = 3'd3;
  localparam rx_state_t RX_WAIT_HIGH = 3'd4;

endpackage

// File: rtl/uart_bus_device_rx.sv
// Receive core: 2-flop synchronizer on rxd, falling-edge start detect,
// mid-bit sampling with a baud counter, LSB-first shift, stop-bit check.
// Ports:
//   clk, rst        clock, async active-high reset
//   rxd             raw serial input (asynchronous)
//   rx_byte         last assembled byte (valid while byte_valid=1)
//   byte_valid      one-cycle pulse when a frame with a good stop bit ends
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLK_DIV = UART_CLK_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] rx_byte,
  output logic       byte_valid
);

  localparam int             CW        = $clog2(CLK_DIV);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  logic          rxd_meta, rxd_sync, rxd_prev;
  rx_state_t     state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;

  // shift only moves in DATA, so it is stable while byte_valid pulses
  assign rx_byte = shift;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_meta   <= 1'b1;
      rxd_sync   <= 1'b1;
      rxd_prev   <= 1'b1;
      state      <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      byte_valid <= 1'b0;
    end else begin
      rxd_meta   <= rxd;
      rxd_sync   <= rxd_meta;
      rxd_prev   <= rxd_sync;
      byte_valid <= 1'b0;
      case (state)
        RX_IDLE: begin
          cnt <= '0;
          if (rxd_prev && !rxd_sync) state <= RX_START;
        end
        RX_START: begin
          // half a bit in: still low means a real start bit, else a glitch
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rxd_sync ? RX_IDLE : RX_DATA;
          end else cnt <= cnt + CNT_ONE;
        end
        RX_DATA: begin
          if (cnt == FULL_LAST) begin
            cnt     <= '0;
            shift   <= {rxd_sync, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= RX_STOP;
          end else cnt <= cnt + CNT_ONE;
        end
        RX_STOP: begin
          if (cnt == FULL_LAST) begin
            cnt <= '0;
            if (rxd_sync) begin
              byte_valid <= 1'b1;
              state      <= RX_IDLE;
            end else begin
              state <= RX_WAIT_HIGH;  // framing error: drop frame, resync on idle line
            end
          end else cnt <= cnt + CNT_ONE;
        end
        RX_WAIT_HIGH: if (rxd_sync) state <= RX_IDLE;
        default:      state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_bus_device.sv
// Device end of the controller's rdn/wrn/tbre/tsre serial-port handshake.
// Writes are latched into THR on the rising edge of wrn and serialized on
// txd; received bytes land in RBR and are read back over bus_data with rdn.
// Ports:
//   clk, rst        clock, async active-high reset
//   bus_data        low byte of shared RAM1 data bus (driven only on read)
//   rdn, wrn        active-low read / write strobes
//   tbre, tsre      transmit holding / shift register empty
//   data_ready      RBR holds unread data
//   txd, rxd        serial out (idles high) / serial in
module uart_bus_device
  import uart_pkg::*;
#(
  parameter int CLK_DIV = UART_CLK_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  inout  wire  [7:0] bus_data,
  input  logic       rdn,
  input  logic       wrn,
  output logic       tbre,
  output logic       tsre,
  output logic       data_ready,
  output logic       txd,
  input  logic       rxd
);

  localparam int             CW        = $clog2(CLK_DIV);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  logic          rdn_q, wrn_q;
  logic          wr_commit, rd_done;
  logic [7:0]    thr, tsr, rbr;
  tx_state_t     tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic          tx_load;
  logic [7:0]    rx_byte;
  logic          byte_valid;

  // Read path: combinational, independent of data_ready. rdn&wrn both low never drives.
  assign bus_data = (!rdn && wrn) ? rbr : 8'bz;

  assign wr_commit = wrn && !wrn_q;
  assign rd_done   = rdn && !rdn_q;

  // TSR takes THR either from idle or straight out of a finished stop bit
  assign tx_load = !tbre && ((tx_state == TX_IDLE) ||
                             (tx_state == TX_STOP && tx_cnt == FULL_LAST));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdn_q <= 1'b1;
      wrn_q <= 1'b1;
      thr   <= '0;
      tbre  <= 1'b1;
    end else begin
      rdn_q <= rdn;
      wrn_q <= wrn;
      // tx_load needs tbre=0 and a commit needs tbre=1, so they never collide
      if (tx_load) tbre <= 1'b1;
      else if (wr_commit && tbre) begin
        thr  <= bus_data;
        tbre <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tsr      <= '0;
      tsre     <= 1'b1;
      txd      <= 1'b1;
    end else begin
      if (tx_load) begin
        tsr      <= thr;
        tsre     <= 1'b0;
        txd      <= 1'b0;
        tx_cnt   <= '0;
        tx_state <= TX_START;
      end else begin
        case (tx_state)
          TX_IDLE: tx_cnt <= '0;
          TX_START: begin
            if (tx_cnt == FULL_LAST) begin
              tx_cnt   <= '0;
              tx_bit   <= '0;
              txd      <= tsr[0];
              tsr      <= {1'b0, tsr[7:1]};
              tx_state <= TX_DATA;
            end else tx_cnt <= tx_cnt + CNT_ONE;
          end
          TX_DATA: begin
            if (tx_cnt == FULL_LAST) begin
              tx_cnt <= '0;
              tx_bit <= tx_bit + 3'd1;
              if (tx_bit == 3'd7) begin
                txd      <= 1'b1;
                tx_state <= TX_STOP;
              end else begin
                txd <= tsr[0];
                tsr <= {1'b0, tsr[7:1]};
              end
            end else tx_cnt <= tx_cnt + CNT_ONE;
          end
          TX_STOP: begin
            // a pending THR at this point is handled by tx_load above
            if (tx_cnt == FULL_LAST) begin
              tx_cnt   <= '0;
              tsre     <= 1'b1;
              tx_state <= TX_IDLE;
            end else tx_cnt <= tx_cnt + CNT_ONE;
          end
          default: tx_state <= TX_IDLE;
        endcase
      end
    end
  end

  uart_rx_core #(.CLK_DIV(CLK_DIV)) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rxd        (rxd),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid)
  );

  // A frame landing on the same edge as a read completing wins: data stays pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rbr        <= '0;
      data_ready <= 1'b0;
    end else if (byte_valid) begin
      rbr        <= rx_byte;
      data_ready <= 1'b1;
    end else if (rd_done) begin
      data_ready <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_bus_device.sv
// Scoreboard bench for uart_bus_device: stimulus pushes expected TX bytes and
// expected RX reads into queues; a txd frame decoder and a bus reader pop and compare.
module tb_uart_bus_device;

  localparam int DIV = 16;

  logic clk = 1'b0, rst = 1'b1, rdn = 1'b1, wrn = 1'b1, rxd = 1'b1;
  logic drv = 1'b0;
  logic [7:0] drv_val = 8'h00;
  wire  [7:0] bus_data;
  wire  tbre, tsre, data_ready, txd;

  assign bus_data = drv ? drv_val : 8'bz;

  uart_bus_device #(.CLK_DIV(DIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus_data   (bus_data),
    .rdn        (rdn),
    .wrn        (wrn),
    .tbre       (tbre),
    .tsre       (tsre),
    .data_ready (data_ready),
    .txd        (txd),
    .rxd        (rxd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int rst_cnt = 0;
  always @(posedge rst) rst_cnt = rst_cnt + 1;

  typedef struct { logic [7:0] b; bit dr; } rx_exp_t;
  logic [7:0] tx_q[$];
  rx_exp_t    rx_q[$];
  int checks = 0, errors = 0;
  int rd_req = 0, rd_done = 0, rx_t0 = 0;

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // returns at the negedge right after the commit edge
  task automatic wr(input logic [7:0] b);
    @(negedge clk); drv_val = b; drv = 1'b1; wrn = 1'b0;
    @(negedge clk); wrn = 1'b1;
    @(negedge clk); drv = 1'b0;
  endtask

  task automatic tsre_rise(output int idx);
    idx = -1;
    for (int i = 1; i <= 1000; i++) begin
      @(negedge clk);
      if (tsre) begin idx = i; break; end
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    @(negedge clk); rxd = 1'b0; rx_t0 = cyc + 1;
    repeat (DIV - 1) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); rxd = b[i];
      repeat (DIV - 1) @(negedge clk);
    end
    @(negedge clk); rxd = stop;
    repeat (DIV - 1) @(negedge clk);
    @(negedge clk); rxd = 1'b1;
  endtask

  task automatic wait_rx_drain();
    for (int i = 0; i < 400; i++) begin
      if (rx_q.size() == 0 && rd_done == rd_req) break;
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    fork
      // ---------------- stimulus ----------------
      begin
        int idx;
        repeat (3) @(negedge clk);
        chk(txd == 1'b1, "reset_txd", txd, 1);
        chk(tbre == 1'b1, "reset_tbre", tbre, 1);
        chk(tsre == 1'b1, "reset_tsre", tsre, 1);
        chk(data_ready == 1'b0, "reset_data_ready", data_ready, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // single byte 0xA5
        tx_q.push_back(8'hA5);
        wr(8'hA5);
        chk(tbre == 1'b0, "t1_tbre_low", tbre, 0);
        @(negedge clk);
        chk(tbre == 1'b1, "t1_tbre_back", tbre, 1);
        chk(tsre == 1'b0, "t1_tsre_busy", tsre, 0);
        chk(txd == 1'b0, "t1_start_bit", txd, 0);
        tsre_rise(idx);
        chk(idx == 160, "t1_tsre_rise", idx, 160);

        // back-to-back 0x3C, 0xC3
        tx_q.push_back(8'h3C); tx_q.push_back(8'hC3);
        wr(8'h3C);
        @(negedge clk);
        wr(8'hC3);
        chk(tbre == 1'b0, "t2_thr_full", tbre, 0);
        tsre_rise(idx);
        chk(idx == 317, "t2_tsre_rise", idx, 317);

        // third write while THR full is dropped
        tx_q.push_back(8'h11); tx_q.push_back(8'h22);
        wr(8'h11);
        @(negedge clk);
        wr(8'h22);
        wr(8'h33);
        chk(tbre == 1'b0, "t3_tbre_held", tbre, 0);
        tsre_rise(idx);
        chk(idx == 314, "t3_tsre_rise", idx, 314);

        // good RX frame
        rx_q.push_back('{8'h5A, 1'b1});
        send_rx(8'h5A, 1'b1);
        wait_rx_drain();

        // 4-cycle glitch
        @(negedge clk); rxd = 1'b0;
        repeat (4) @(negedge clk); rxd = 1'b1;
        repeat (300) @(negedge clk);
        chk(data_ready == 1'b0, "glitch_no_frame", data_ready, 0);

        // framing error, RBR must still hold 0x5A
        send_rx(8'hFF, 1'b0);
        repeat (300) @(negedge clk);
        chk(data_ready == 1'b0, "framing_err_dropped", data_ready, 0);
        rx_q.push_back('{8'h5A, 1'b0});
        rd_req++;
        wait_rx_drain();

        // reset 50 cycles into a frame
        wr(8'h77);
        @(negedge clk);
        repeat (49) @(negedge clk);
        rst = 1'b1;
        #1;
        chk(txd == 1'b1, "rst_txd", txd, 1);
        chk(tbre == 1'b1, "rst_tbre", tbre, 1);
        chk(tsre == 1'b1, "rst_tsre", tsre, 1);
        @(negedge clk); rst = 1'b0;
        repeat (200) @(negedge clk);
        tx_q.push_back(8'h96);
        wr(8'h96);
        @(negedge clk);
        chk(txd == 1'b0, "post_rst_start", txd, 0);
        tsre_rise(idx);
        chk(idx == 160, "post_rst_tsre_rise", idx, 160);

        for (int i = 0; i < 500; i++) begin
          if (tx_q.size() == 0 && rx_q.size() == 0) break;
          @(negedge clk);
        end
        chk(tx_q.size() == 0, "tx_q_drained", tx_q.size(), 0);
        chk(rx_q.size() == 0, "rx_q_drained", rx_q.size(), 0);
      end

      // ---------------- txd frame monitor ----------------
      begin
        int rc;
        logic st, sp;
        logic [7:0] b, e;
        forever begin
          @(negedge clk);
          if (txd == 1'b0 && !rst) begin
            rc = rst_cnt;
            repeat (DIV / 2) @(negedge clk);
            st = txd;
            for (int i = 0; i < 8; i++) begin
              repeat (DIV) @(negedge clk);
              b[i] = txd;
            end
            repeat (DIV) @(negedge clk);
            sp = txd;
            if (rst_cnt == rc) begin
              if (tx_q.size() == 0) chk(1'b0, "tx_unexpected_frame", b, 0);
              else begin
                e = tx_q.pop_front();
                chk(b == e, "tx_byte", b, e);
                chk(!st && sp, "tx_framing", {st, sp}, 1);
              end
            end
          end
        end
      end

      // ---------------- bus read monitor ----------------
      begin
        bit req;
        bit dr0;
        int lat;
        rx_exp_t e;
        forever begin
          @(negedge clk);
          if (data_ready || rd_req != rd_done) begin
            req = (rd_req != rd_done);
            dr0 = data_ready;
            lat = cyc - rx_t0;
            if (rx_q.size() == 0) begin
              chk(1'b0, "rx_unexpected_data", dr0, 0);
              e = '{8'h00, 1'b1};
            end else e = rx_q.pop_front();
            if (!req) chk(lat >= 154 && lat <= 156, "rx_latency", lat, 155);
            chk(dr0 == e.dr, "rx_data_ready", dr0, e.dr);
            rdn = 1'b0;
            #1;
            chk(bus_data == e.b, "rx_bus_data", bus_data, e.b);
            @(negedge clk); rdn = 1'b1;
            @(negedge clk);
            chk(data_ready == 1'b0, "rx_read_clears", data_ready, 0);
            if (req) rd_done++;
          end
        end
      end
    join_any
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
